// File: rtl/bp_common_pkg.sv
// Shared FE command-channel types: opcode enums, packed command layout and
// the decoded action vector passed from the opcode decoder to the FE sequencer.
package bp_common_pkg;

   localparam int vaddr_width_gp = 39;
   localparam int bmeta_width_gp = 36;
   localparam int pte_width_gp   = 64;

   typedef enum logic [3:0] {
      e_op_state_reset          = 4'd0,
      e_op_pc_redirection       = 4'd1,
      e_op_icache_fill_response = 4'd2,
      e_op_icache_fence         = 4'd3,
      e_op_attaboy              = 4'd4,
      e_op_itlb_fill_response   = 4'd5,
      e_op_itlb_fence           = 4'd6,
      e_op_wait                 = 4'd7
   } bp_fe_command_queue_opcodes_e;

   typedef enum logic [2:0] {
      e_subop_translation_switch = 3'd0,
      e_subop_eret               = 3'd1,
      e_subop_interrupt          = 3'd2,
      e_subop_branch_mispredict  = 3'd3,
      e_subop_trap               = 3'd4,
      e_subop_context_switch     = 3'd5,
      e_subop_resume             = 3'd6
   } bp_fe_command_queue_subopcodes_e;

   typedef enum logic [1:0] {
      e_incorrect_pred_taken  = 2'd0,
      e_incorrect_pred_ntaken = 2'd1,
      e_not_a_branch          = 2'd2
   } bp_fe_misprediction_reason_e;

   // Every operand view is padded to the widest member (the ITLB fill PTE).
   localparam int fe_cmd_operands_width_gp = pte_width_gp;
   localparam int redirect_pad_width_gp    = fe_cmd_operands_width_gp - (3 + 2 + 2 + 1 + bmeta_width_gp);
   localparam int attaboy_pad_width_gp     = fe_cmd_operands_width_gp - (1 + bmeta_width_gp);

   // Used by pc_redirection and state_reset alike.
   typedef struct packed {
      logic [redirect_pad_width_gp-1:0] pad;
      bp_fe_command_queue_subopcodes_e  subop;
      bp_fe_misprediction_reason_e      reason;
      logic [1:0]                       priv;
      logic                             tr_en;
      logic [bmeta_width_gp-1:0]        meta;
   } bp_fe_cmd_pc_redirect_operands_s;

   typedef struct packed {
      logic [attaboy_pad_width_gp-1:0] pad;
      logic                            taken;
      logic [bmeta_width_gp-1:0]       meta;
   } bp_fe_cmd_attaboy_s;

   typedef struct packed {
      logic [pte_width_gp-1:0] pte;
   } bp_fe_cmd_itlb_fill_response_s;

   typedef union packed {
      bp_fe_cmd_pc_redirect_operands_s pc_redirect;
      bp_fe_cmd_attaboy_s              attaboy;
      bp_fe_cmd_itlb_fill_response_s   itlb_fill;
   } bp_fe_cmd_operands_u;

   typedef struct packed {
      bp_fe_command_queue_opcodes_e opcode;
      logic [vaddr_width_gp-1:0]    npc;
      bp_fe_cmd_operands_u          operands;
   } bp_fe_cmd_s;

   localparam int fe_cmd_width_gp = $bits(bp_fe_cmd_s);

   typedef enum logic [1:0] {
      e_reset = 2'd0,
      e_run   = 2'd1,
      e_fence = 2'd2,
      e_wait  = 2'd3
   } bp_fe_cmd_decoder_state_e;

   typedef struct packed {
      logic                      redirect;
      logic                      load_priv;
      logic [1:0]                priv;
      logic                      tr_en;
      logic                      br_update;
      logic                      mispredict;
      logic                      taken;
      logic [bmeta_width_gp-1:0] meta;
      logic                      itlb_w;
      logic                      itlb_flush;
      logic                      icache_fence;
      logic                      state_reset;
      logic                      go_wait;
      logic                      resume;
      logic                      need_idle;
   } bp_fe_cmd_action_s;

endpackage

// File: rtl/bp_fe_cmd_decoder_decode_comb.sv
// Pure opcode-to-action decode of one FE command; no state, no gating by FSM.
module bp_fe_cmd_decode_comb
   import bp_common_pkg::*;
(
   input  bp_fe_cmd_s        fe_cmd_i,
   output bp_fe_cmd_action_s action_o
);

   bp_fe_cmd_pc_redirect_operands_s redir;
   bp_fe_cmd_attaboy_s              ab;
   logic                            unused_bits;

   assign redir       = fe_cmd_i.operands.pc_redirect;
   assign ab          = fe_cmd_i.operands.attaboy;
   assign unused_bits = ^{fe_cmd_i.npc, redir.pad, ab.pad};

   always_comb begin
      action_o       = '0;
      action_o.priv  = redir.priv;
      action_o.tr_en = redir.tr_en;
      action_o.meta  = redir.meta;
      // A mispredict resolved as taken is one the predictor called not-taken.
      action_o.taken = (redir.reason == e_incorrect_pred_ntaken);
      case (fe_cmd_i.opcode)
         e_op_state_reset: begin
            action_o.redirect    = 1'b1;
            action_o.load_priv   = 1'b1;
            action_o.state_reset = 1'b1;
            action_o.need_idle   = 1'b1;
         end
         e_op_pc_redirection: begin
            action_o.redirect  = 1'b1;
            action_o.load_priv = 1'b1;
            action_o.resume    = (redir.subop == e_subop_resume);
            if (redir.subop == e_subop_branch_mispredict) begin
               action_o.br_update  = 1'b1;
               action_o.mispredict = 1'b1;
            end
         end
         e_op_icache_fill_response: action_o.redirect = 1'b1;
         e_op_icache_fence: begin
            action_o.icache_fence = 1'b1;
            action_o.need_idle    = 1'b1;
         end
         e_op_attaboy: begin
            action_o.br_update = 1'b1;
            action_o.taken     = ab.taken;
            action_o.meta      = ab.meta;
         end
         e_op_itlb_fill_response: begin
            action_o.itlb_w   = 1'b1;
            action_o.redirect = 1'b1;
         end
         e_op_itlb_fence: begin
            action_o.itlb_flush = 1'b1;
            action_o.redirect   = 1'b1;
         end
         e_op_wait: action_o.go_wait = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/bp_fe_cmd_decoder.sv
// FE end of the BE-to-FE command channel: accepts commands, sequences fence and
// wait, and drives registered one-cycle action pulses plus a mispredict counter.
module bp_fe_cmd_decoder
   import bp_common_pkg::*;
#(
   parameter int vaddr_width_p  = vaddr_width_gp,
   parameter int bmeta_width_p  = bmeta_width_gp,
   parameter int pte_width_p    = pte_width_gp,
   parameter int fe_cmd_width_p = fe_cmd_width_gp,
   parameter int cnt_width_p    = 16
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic [fe_cmd_width_p-1:0] fe_cmd_i,
   input  logic                     fe_cmd_v_i,
   output logic                     fe_cmd_yumi_o,
   input  logic                     icache_busy_i,
   input  logic                     icache_fence_done_i,
   output logic                     redirect_v_o,
   output logic [vaddr_width_p-1:0] redirect_npc_o,
   output logic [1:0]               redirect_priv_o,
   output logic                     redirect_tr_en_o,
   output logic                     br_update_v_o,
   output logic                     br_update_mispredict_o,
   output logic                     br_update_taken_o,
   output logic [bmeta_width_p-1:0] br_update_meta_o,
   output logic                     itlb_w_v_o,
   output logic [vaddr_width_p-1:0] itlb_w_vaddr_o,
   output logic [pte_width_p-1:0]   itlb_w_pte_o,
   output logic                     itlb_flush_o,
   output logic                     icache_fence_v_o,
   output logic                     state_reset_o,
   output logic                     fe_waiting_o,
   output logic [cnt_width_p-1:0]   mispredict_cnt_o
);

   bp_fe_cmd_s               cmd;
   bp_fe_cmd_action_s        act;
   bp_fe_cmd_decoder_state_e state_q, state_d;
   logic                     accept;
   logic                     redirect_v_d, br_update_v_d, itlb_w_v_d;
   logic                     itlb_flush_d, icache_fence_v_d, state_reset_d, load_priv_d;
   logic [vaddr_width_p-1:0] redirect_npc_d;

   logic                     redirect_v_q, br_update_v_q, itlb_w_v_q;
   logic                     itlb_flush_q, icache_fence_v_q, state_reset_q;
   logic [vaddr_width_p-1:0] redirect_npc_q, itlb_w_vaddr_q, fence_npc_q;
   logic [1:0]               priv_q;
   logic                     tr_en_q, mispredict_q, taken_q;
   logic [bmeta_width_p-1:0] meta_q;
   logic [pte_width_p-1:0]   pte_q;
   logic [cnt_width_p-1:0]   cnt_q;

   assign cmd = fe_cmd_i;

   bp_fe_cmd_decode_comb decode (
      .fe_cmd_i (cmd),
      .action_o (act)
   );

   always_comb begin
      accept = 1'b0;
      unique case (state_q)
         e_reset: accept = ~(act.state_reset & icache_busy_i);
         e_run:   accept = ~(act.need_idle & icache_busy_i);
         e_fence: accept = 1'b0;
         e_wait:  accept = act.resume | (act.state_reset & ~icache_busy_i);
      endcase
   end

   assign fe_cmd_yumi_o = fe_cmd_v_i & accept;

   always_comb begin
      state_d          = state_q;
      redirect_v_d     = 1'b0;
      br_update_v_d    = 1'b0;
      itlb_w_v_d       = 1'b0;
      itlb_flush_d     = 1'b0;
      icache_fence_v_d = 1'b0;
      state_reset_d    = 1'b0;
      load_priv_d      = 1'b0;
      redirect_npc_d   = cmd.npc;
      unique case (state_q)
         e_reset: begin
            // Until the FE is brought up, everything but state_reset is discarded.
            if (fe_cmd_yumi_o && act.state_reset) begin
               redirect_v_d  = 1'b1;
               load_priv_d   = 1'b1;
               state_reset_d = 1'b1;
               state_d       = e_run;
            end
         end
         e_run: begin
            if (fe_cmd_yumi_o) begin
               redirect_v_d     = act.redirect;
               load_priv_d      = act.load_priv;
               br_update_v_d    = act.br_update;
               itlb_w_v_d       = act.itlb_w;
               itlb_flush_d     = act.itlb_flush;
               icache_fence_v_d = act.icache_fence;
               state_reset_d    = act.state_reset;
               if (act.icache_fence) state_d = e_fence;
               if (act.go_wait)      state_d = e_wait;
            end
         end
         e_fence: begin
            if (icache_fence_done_i) begin
               redirect_v_d   = 1'b1;
               redirect_npc_d = fence_npc_q;
               state_d        = e_run;
            end
         end
         e_wait: begin
            if (fe_cmd_yumi_o) begin
               redirect_v_d  = 1'b1;
               load_priv_d   = 1'b1;
               state_reset_d = act.state_reset;
               state_d       = e_run;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q          <= e_reset;
         redirect_v_q     <= 1'b0;
         br_update_v_q    <= 1'b0;
         itlb_w_v_q       <= 1'b0;
         itlb_flush_q     <= 1'b0;
         icache_fence_v_q <= 1'b0;
         state_reset_q    <= 1'b0;
         redirect_npc_q   <= '0;
         itlb_w_vaddr_q   <= '0;
         fence_npc_q      <= '0;
         priv_q           <= '0;
         tr_en_q          <= 1'b0;
         mispredict_q     <= 1'b0;
         taken_q          <= 1'b0;
         meta_q           <= '0;
         pte_q            <= '0;
         cnt_q            <= '0;
      end else begin
         state_q          <= state_d;
         redirect_v_q     <= redirect_v_d;
         br_update_v_q    <= br_update_v_d;
         itlb_w_v_q       <= itlb_w_v_d;
         itlb_flush_q     <= itlb_flush_d;
         icache_fence_v_q <= icache_fence_v_d;
         state_reset_q    <= state_reset_d;
         if (redirect_v_d) redirect_npc_q <= redirect_npc_d;
         // Fills and fences keep the current privilege; only commands carrying it reload it.
         if (redirect_v_d && load_priv_d) begin
            priv_q  <= act.priv;
            tr_en_q <= act.tr_en;
         end
         if (br_update_v_d) begin
            mispredict_q <= act.mispredict;
            taken_q      <= act.taken;
            meta_q       <= act.meta;
            if (act.mispredict && (cnt_q != '1)) cnt_q <= cnt_q + cnt_width_p'(1);
         end
         if (itlb_w_v_d) begin
            itlb_w_vaddr_q <= cmd.npc;
            pte_q          <= cmd.operands.itlb_fill.pte;
         end
         if (icache_fence_v_d) fence_npc_q <= cmd.npc;
      end
   end

   assign redirect_v_o           = redirect_v_q;
   assign redirect_npc_o         = redirect_npc_q;
   assign redirect_priv_o        = priv_q;
   assign redirect_tr_en_o       = tr_en_q;
   assign br_update_v_o          = br_update_v_q;
   assign br_update_mispredict_o = mispredict_q;
   assign br_update_taken_o      = taken_q;
   assign br_update_meta_o       = meta_q;
   assign itlb_w_v_o             = itlb_w_v_q;
   assign itlb_w_vaddr_o         = itlb_w_vaddr_q;
   assign itlb_w_pte_o           = pte_q;
   assign itlb_flush_o           = itlb_flush_q;
   assign icache_fence_v_o       = icache_fence_v_q;
   assign state_reset_o          = state_reset_q;
   assign fe_waiting_o           = (state_q == e_wait);
   assign mispredict_cnt_o       = cnt_q;

endmodule

// File: doc/bp_fe_cmd_decoder.md
Name: bp_fe_cmd_decoder

Overview:
FE-side terminus of the BE-to-FE command channel. Consumes commands from the BE command queue (valid/yumi) and decodes each opcode into registered one-cycle action pulses for the FE:
- PC redirect
- branch-predictor update (attaboy / mispredict)
- ITLB fill and fence
- I-cache fence
- FE state reset

It sequences the multi-cycle commands (I-cache fence, wait) with a small FSM and keeps a saturating mispredict counter.

Parameters:
vaddr_width_p, 39, virtual address / npc width
bmeta_width_p, 36, branch_metadata_fwd width
pte_width_p, 64, leaf PTE width carried by ITLB fill
fe_cmd_width_p, derived from bp_fe_cmd_s, packed command width
cnt_width_p, 16, mispredict counter width

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
fe_cmd_i  in  fe_cmd_width_p  packed bp_fe_cmd_s (opcode, npc, operands union)
fe_cmd_v_i  in  1  command valid
fe_cmd_yumi_o  out  1  command consumed this cycle
icache_busy_i  in  1  I-cache has a miss/fill outstanding
icache_fence_done_i  in  1  I-cache fence complete (single-cycle pulse)
redirect_v_o  out  1  PC redirect pulse
redirect_npc_o  out  vaddr_width_p  redirect target
redirect_priv_o  out  2  new privilege (valid with redirect_v_o)
redirect_tr_en_o  out  1  new translation enable (valid with redirect_v_o)
br_update_v_o  out  1  predictor update pulse
br_update_mispredict_o  out  1  1 = mispredict, 0 = attaboy
br_update_taken_o  out  1  resolved direction
br_update_meta_o  out  bmeta_width_p  branch_metadata_fwd
itlb_w_v_o  out  1  ITLB fill write pulse
itlb_w_vaddr_o  out  vaddr_width_p  fill vaddr
itlb_w_pte_o  out  pte_width_p  fill PTE
itlb_flush_o  out  1  ITLB flush pulse
icache_fence_v_o  out  1  I-cache fence start pulse
state_reset_o  out  1  FE state reset pulse
fe_waiting_o  out  1  level, high in e_wait
mispredict_cnt_o  out  cnt_width_p  saturating mispredict count

Behaviour:
Reset values:
- Async: reset_n_i low immediately clears all registers.
- All pulse outputs 0, npc/meta/pte outputs 0, fe_waiting_o 0, mispredict_cnt_o 0, state e_reset.
- Mid-fence or mid-wait reset abandons the operation; no done/pulse is emitted.

Yumi and output timing:
- fe_cmd_yumi_o is combinational: fe_cmd_v_i & accept, where accept depends on state (below).
- Never asserted without fe_cmd_v_i.
- At most one command per cycle.
- All action outputs are registered: they assert in the cycle after yumi, last exactly 1 cycle, and data fields hold until the next action.

FSM:
- e_reset
  - state_reset: accepted only when !icache_busy_i → state_reset_o and redirect (npc, priv, tr_en) → e_run.
  - Any other opcode: yumied and dropped, no outputs.
- e_run: accept = 1, except icache_fence and state_reset, which require !icache_busy_i. Decode:
  - pc_redirection → redirect. If subop is branch_mispredict, also br_update with mispredict=1, taken=(reason==incorrect_pred_ntaken), meta; counter increments.
  - attaboy → br_update, mispredict=0, taken, meta; no redirect.
  - itlb_fill_response → itlb_w_v_o and redirect to npc.
  - icache_fill_response → redirect to npc.
  - itlb_fence → itlb_flush_o and redirect.
  - icache_fence → icache_fence_v_o → e_fence.
  - wait → e_wait.
  - state_reset → state_reset_o and redirect (stays e_run).
- e_fence
  - accept = 0.
  - On icache_fence_done_i → redirect to the latched fence npc the next cycle → e_run.
  - A done arriving in the same cycle that icache_fence_v_o is high is honoured.
- e_wait
  - fe_waiting_o = 1.
  - Accept only pc_redirection with subop resume, or state_reset → redirect (plus state_reset_o for state_reset) → e_run.
  - Other opcodes are not yumied and stay at the queue head.

Counter: mispredict_cnt_o saturates at all-ones and does not wrap.

Unknown opcode: yumied and dropped in every accepting state.

Decomposition:
- bp_common_pkg supplies bp_fe_cmd_s, the opcode/subopcode/misprediction_reason enums, and the width macros; add an FSM state enum bp_fe_cmd_decoder_state_e there.
- One sub-module, bp_fe_cmd_decode_comb: purely combinational opcode-to-action-vector decode. The top level holds the FSM, output registers and counter.

Test Plan:
- Reset → state_reset (npc=0x8000_0000, priv=3) with icache_busy_i=1 for 3 cycles → no yumi for 3 cycles; then yumi, next cycle state_reset_o=1, redirect_npc_o=0x8000_0000.
- In e_run, attaboy (taken=1, meta=0x5A) then pc_redirection/branch_mispredict/incorrect_pred_ntaken (npc=0x1000) back-to-back → yumi both cycles; br_update mispredict=0/taken=1, then mispredict=1/taken=1 with redirect_npc_o=0x1000; mispredict_cnt_o=1.
- icache_fence (npc=0x2000) → icache_fence_v_o pulse; queued attaboy held (no yumi); done pulse 5 cycles later → redirect to 0x2000, attaboy yumied the following cycle.
- wait, then attaboy, then pc_redirection/resume (npc=0x3000) → fe_waiting_o=1 and attaboy stalls indefinitely. Test as a separate sequence in which the resume is at the queue head: resume is yumied, redirect goes to 0x3000, fe_waiting_o=0.
- itlb_fill_response (vaddr=0x4000, pte=0xABC) → itlb_w_v_o with vaddr=0x4000, pte=0xABC and redirect to 0x4000 in the same cycle.
- Force mispredict_cnt_o=0xFFFE, issue 3 mispredicts → counter stays 0xFFFF. Assert reset_n_i mid-e_fence → all outputs 0 asynchronously, state e_reset.
